bm_pipe: RTL
============

# bm_pipe

Parametrised, pipelined branch-metric unit for the MAP decoder datapath. Per trellis step it takes the systematic soft value, the parity soft value and the a-priori LLR, and produces the four normalised branch metrics (gamma_00, gamma_01, gamma_10, gamma_11) consumed by the alpha/beta recursion units. It succeeds the combinational 4-bit metric block with:
- configurable width;
- a valid/ready handshaked two-stage pipeline;
- per-frame symbol indexing with frame-length checking;
- a selectable a-priori bypass mode.

## Interface
Parameters:
- W, 6: width of each signed soft input (two's complement).
- K_MAX, 64: maximum symbols per frame; index width IW = clog2(K_MAX).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- apr_en  in  1  1 = include a-priori LLR in systematic metric; 0 = treat it as 0. Sampled per beat with the data.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- in_ys  in  W  systematic soft value, signed.
- in_yp  in  W  parity soft value, signed.
- in_la  in  W  a-priori LLR, signed.
- in_last  in  1  beat is final symbol of the frame.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_g00, out_g01, out_g10, out_g11  out  W+2 each  signed branch metrics.
- out_idx  out  IW  symbol index within the frame, 0-based.
- out_last  out  1  in_last, delayed through the pipeline.
- len_err  out  1  sticky frame-length error flag.
- err_clr  in  1  synchronous clear of len_err.

## Operation
Arithmetic:
- All arithmetic is signed.
- Inputs are sign-extended to W+2 bits before any operation.
- No saturation is needed: the maximum magnitude 3·2^(W-1) fits in W+2 bits.

Metric definitions:
- s = in_ys + (apr_en ? in_la : 0).
- g00 = 0.
- g01 = yp.
- g10 = s.
- g11 = s + yp.

Pipeline:
- Stage 1 (S1) registers s, yp, last and idx.
- Stage 2 (S2) registers the four gammas, idx and last.
- Each stage has a valid bit.
- A beat is accepted when in_valid && in_ready.
- Stage advance: S2 loads when !s2_valid || out_ready; S1 loads when S2 can load or !s1_valid.
- in_ready = !s1_valid || s2_can_load. Combinational from out_ready is allowed.

Frame index:
- An index counter increments on each accepted beat and is captured into S1 along with the beat.
- On an accepted beat with in_last = 1, the counter returns to 0.
- If the counter is K_MAX-1 and the accepted beat has in_last = 0:
  - the counter wraps to 0;
  - len_err is set.

len_err:
- Sticky until err_clr or rst.
- If err_clr and a new error occur in the same cycle, set wins.

Mid-frame reset: rst at any time empties both stages and zeroes the counter; no partial beat is emitted afterwards.

## Timing
- Reset values:
  - in_ready = 1; out_valid = 0; all out_g* = 0; out_idx = 0; out_last = 0; len_err = 0.
  - Internal valids and counter = 0.
- Latency: 2 cycles from acceptance to out_valid, with out_ready held high.
- Throughput: 1 beat/cycle sustained.
- Stall behaviour:
  - While out_valid && !out_ready, all outputs hold stable.
  - Up to 2 beats are buffered; no beat is dropped or duplicated.
- Simultaneous events:
  - S2 draining while S1 and the input advance in the same cycle is a legal full-throughput case.
- apr_en applies to the beat it accompanies, not to beats already in flight.

## Structure
- Shared package bm_pkg holds:
  - function clog2;
  - the localparam GW = W+2 convention;
  - the gamma ordering constants (G00..G11) used by the recursion units.
- One sub-module: bm_calc. It is combinational, maps (s, yp) to the four gammas, and is reused later by the extrinsic-LLR unit.
- Handshake, stage registers, counter and error logic live in bm_pipe.

## Test plan
- Reset, then W=6, apr_en=1, ys=5, yp=-3, la=2, out_ready=1 -> two cycles later g00=0, g01=-3, g10=7, g11=4, idx=0.
- apr_en=0, same beat -> g10=5, g11=2.
- Extremes ys=-32, la=-32, yp=-32, apr_en=1 -> g11=-96 exactly, no wrap.
- Frame of 4 beats with in_last on the 4th, out_ready toggling 1/0 each cycle -> idx 0,1,2,3 in order, out_last only on idx 3, data stable during stalls, next frame restarts at 0.
- K_MAX=4, 5 beats with no in_last -> len_err rises on the 4th accepted beat, 5th beat has idx 0; err_clr clears it one cycle later.
- rst asserted with both stages full -> out_valid=0 immediately; the next accepted beat emerges with idx 0.

Source files
------------

// File: rtl/bm_pkg.sv
// Shared definitions for the MAP branch-metric datapath: gamma ordering,
// metric width growth and a constant clog2 helper.
package bm_pkg;

  // ys + la + yp spans at most 3*2^(W-1), which needs two extra bits
  localparam int GW_PAD = 2;
  localparam int N_GAMMA = 4;

  typedef enum logic [1:0] {
    G00 = 2'd0,
    G01 = 2'd1,
    G10 = 2'd2,
    G11 = 2'd3
  } gamma_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int gw(input int w);
    return w + GW_PAD;
  endfunction

endpackage

// File: rtl/bm_pipe_if.sv
// Beat-level bus of the branch-metric unit: soft inputs with valid/ready in,
// gammas with valid/ready out, plus the sticky frame-length error.
interface bm_pipe_if #(
  parameter int W = 6,
  parameter int K_MAX = 64
);
  import bm_pkg::*;

  localparam int GW = gw(W);
  localparam int IW = clog2(K_MAX);

  logic                 apr_en;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  in_ys;
  logic signed [W-1:0]  in_yp;
  logic signed [W-1:0]  in_la;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [GW-1:0] out_g00;
  logic signed [GW-1:0] out_g01;
  logic signed [GW-1:0] out_g10;
  logic signed [GW-1:0] out_g11;
  logic [IW-1:0]        out_idx;
  logic                 out_last;
  logic                 len_err;
  logic                 err_clr;

  modport master (
    output apr_en, in_valid, in_ys, in_yp, in_la, in_last, out_ready, err_clr,
    input  in_ready, out_valid, out_g00, out_g01, out_g10, out_g11,
           out_idx, out_last, len_err
  );

  modport slave (
    input  apr_en, in_valid, in_ys, in_yp, in_la, in_last, out_ready, err_clr,
    output in_ready, out_valid, out_g00, out_g01, out_g10, out_g11,
           out_idx, out_last, len_err
  );

endinterface

// File: rtl/bm_calc.sv
// Combinational gamma mapping from (s, yp); zero latency, no flow control.
// Reused by the extrinsic-LLR unit, so it stays free of any pipeline state.
module bm_calc import bm_pkg::*; #(
  parameter int GW = 8
) (
  input  logic signed [GW-1:0]       s,
  input  logic signed [GW-1:0]       yp,
  output logic [N_GAMMA-1:0][GW-1:0] gam
);

  always_comb begin
    gam      = '0;
    gam[G00] = '0;
    gam[G01] = yp;
    gam[G10] = s;
    gam[G11] = s + yp;
  end

endmodule

// File: rtl/bm_pipe.sv
// Two-stage branch-metric pipeline with frame indexing; 2-cycle latency, 1 beat/cycle.
// Backpressure: out_ready stalls S2, S1 fills behind it, in_ready drops once both hold a beat.
module bm_pipe import bm_pkg::*; #(
  parameter int W = 6,
  parameter int K_MAX = 64
) (
  input logic      clk,
  input logic      rst,
  bm_pipe_if.slave bus
);

  localparam int GW = gw(W);
  localparam int IW = clog2(K_MAX);
  localparam logic [IW-1:0] IDX_MAX = IW'(K_MAX - 1);

  logic                       s1_valid, s1_last;
  logic signed [GW-1:0]       s1_s, s1_yp;
  logic [IW-1:0]              s1_idx;
  logic                       s2_valid, s2_last;
  logic [N_GAMMA-1:0][GW-1:0] s2_g;
  logic [IW-1:0]              s2_idx;
  logic [IW-1:0]              cnt;
  logic                       err;

  logic                       s2_can_load, s1_can_load, accept, cnt_wrap;
  logic signed [GW-1:0]       ys_x, yp_x, la_x, s_in;
  logic [N_GAMMA-1:0][GW-1:0] gam;

  assign s2_can_load = !s2_valid || bus.out_ready;
  assign s1_can_load = s2_can_load || !s1_valid;
  assign accept      = bus.in_valid && s1_can_load;
  // Frame overran K_MAX symbols without in_last
  assign cnt_wrap    = accept && !bus.in_last && (cnt == IDX_MAX);

  assign ys_x = {{GW_PAD{bus.in_ys[W-1]}}, bus.in_ys};
  assign yp_x = {{GW_PAD{bus.in_yp[W-1]}}, bus.in_yp};
  assign la_x = {{GW_PAD{bus.in_la[W-1]}}, bus.in_la};
  assign s_in = ys_x + (bus.apr_en ? la_x : GW'(0));

  bm_calc #(.GW(GW)) u_calc (
    .s   (s1_s),
    .yp  (s1_yp),
    .gam (gam)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_s     <= '0;
      s1_yp    <= '0;
      s1_idx   <= '0;
      s1_last  <= 1'b0;
    end else if (s1_can_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_s    <= s_in;
        s1_yp   <= yp_x;
        s1_idx  <= cnt;
        s1_last <= bus.in_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_g     <= '0;
      s2_idx   <= '0;
      s2_last  <= 1'b0;
    end else if (s2_can_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_g    <= gam;
        s2_idx  <= s1_idx;
        s2_last <= s1_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      if (bus.in_last || cnt_wrap) cnt <= '0;
      else                         cnt <= cnt + IW'(1);
    end
  end

  // A fresh error outranks a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              err <= 1'b0;
    else if (cnt_wrap)    err <= 1'b1;
    else if (bus.err_clr) err <= 1'b0;
  end

  assign bus.in_ready  = s1_can_load;
  assign bus.out_valid = s2_valid;
  assign bus.out_g00   = s2_g[G00];
  assign bus.out_g01   = s2_g[G01];
  assign bus.out_g10   = s2_g[G10];
  assign bus.out_g11   = s2_g[G11];
  assign bus.out_idx   = s2_idx;
  assign bus.out_last  = s2_last;
  assign bus.len_err   = err;

endmodule
